iic_cfg_sequencer: RTL
======================

# iic_cfg_sequencer

Boot-time configuration sequencer for one IIC channel of the PCA9548 switch front end. After START it walks an external command table of single-byte register writes (device, word address, data), issues each as a channel request, and retries failed entries. It reports done or failure with the failing index. It replaces ad-hoc per-device init logic for the clock synthesiser and PHY-side devices behind the switch.

## Interface
- ENTRIES, 8'd32: table depth; valid index range 0..ENTRIES-1.
- RETRY, 2'd3: extra attempts per entry after the first failure.
- GAP, 16'd2000: idle CLK_IN cycles between a failed attempt and its retry.
- CLK_IN  in  1  system clock.
- RESET_IN  in  1  asynchronous, active-high reset.
- START_IN  in  1  one-cycle start pulse; ignored unless in IDLE, DONE or FAIL.
- BUSY_OUT / DONE_OUT / FAIL_OUT  out  1 each  status levels.
- ERR_IDX_OUT  out  8  index of the failing entry; valid while FAIL_OUT is high.
- TBL_ADR_OUT  out  8  table read address.
- TBL_DAT_IN  in  24  table entry, read with 1-cycle latency:
  - [23] LAST flag.
  - [22:16] DAD.
  - [15:8] ADR.
  - [7:0] DATA.
- IIC_REQ_OUT, IIC_NUM_OUT[7:0], IIC_DAD_OUT[6:0], IIC_ADR_OUT[7:0], IIC_RNW_OUT, IIC_WDT_OUT[7:0]  out  channel request side.
- IIC_RAK_IN, IIC_WDA_IN, IIC_WAE_IN, IIC_BSY_IN, IIC_RDT_IN[7:0], IIC_RVL_IN, IIC_EOR_IN, IIC_ERR_IN  in  channel response side.
- INIT_ERR_IN  in  1  switch init failure; forces FAIL.

## Operation
- States: IDLE, FETCH, LOAD, REQ, XFER, (VREQ, VXFER), CHECK, GAP, DONE, FAIL.
- IDLE/DONE/FAIL + START_IN -> FETCH:
  - index=0, attempt=0, DONE_OUT/FAIL_OUT cleared, BUSY_OUT=1.
- FETCH: TBL_ADR_OUT=index. -> LOAD.
- LOAD: register entry fields. -> REQ.
  - IIC_NUM_OUT=8'h00 (1 byte), IIC_RNW_OUT=0.
  - IIC_WDT_OUT=DATA; held constant for the whole transaction.
- REQ: IIC_REQ_OUT=1 until IIC_RAK_IN is sampled high; REQ drops the cycle after. -> XFER.
- XFER: the sticky flag err_f is set by IIC_ERR_IN & IIC_BSY_IN.
  - Completion is the first cycle IIC_BSY_IN=0 after RAK. -> CHECK (or VREQ when verify is compiled in and err_f=0).
  - IIC_WDA_IN and IIC_WAE_IN are observed only; a missing WDA is not an error.
- CHECK:
  - err_f=0 and LAST=1 -> DONE.
  - err_f=0 and LAST=0 -> index+1, attempt=0, FETCH.
  - err_f=1 and attempt<RETRY -> attempt+1, GAP.
  - err_f=1 and attempt=RETRY -> FAIL, ERR_IDX_OUT=index.
- Index reaching ENTRIES-1 without LAST is treated as LAST; index never wraps.
- GAP: counter loads GAP-1 and counts to 0. -> LOAD; the same entry is reused, no refetch.
- INIT_ERR_IN=1 in any non-IDLE state -> FAIL with ERR_IDX_OUT=8'hFF.
  - If a request is outstanding, FAIL is entered only after IIC_BSY_IN falls.
- DONE and FAIL hold until the next START_IN. BUSY_OUT=0 in IDLE, DONE and FAIL.

## Timing
- Reset values: all outputs 0; state IDLE; ERR_IDX_OUT=8'h00.
- Reset mid-transaction: IIC_REQ_OUT drops asynchronously; the channel completes or aborts on its own.
- START to first IIC_REQ_OUT: 3 cycles (FETCH, LOAD, REQ).
- RAK sampled to REQ low: 1 cycle. REQ is never re-asserted while IIC_BSY_IN=1.
- IIC_BSY_IN low to next entry's REQ: CHECK, FETCH, LOAD, REQ = 4 cycles. On retry: GAP + 2 cycles.
- IIC_ERR_IN and IIC_RAK_IN in the same cycle: the error is counted for the current attempt.
- START_IN coinciding with a reset release edge is ignored.

## Configuration
- IIC_SEQ_VERIFY_EN defined: after a clean write, run a readback.
  - VREQ issues a 1-byte read with the same DAD/ADR, RNW=1.
  - VXFER captures IIC_RDT_IN on IIC_RVL_IN.
  - A capture not equal to DATA, no RVL before BSY falls, or ERR sets err_f. -> CHECK.
- Undefined: VREQ/VXFER are absent; the channel never sees RNW=1.

## Structure
- Package iic_seq_pkg holds:
  - The state enum.
  - Entry field bit positions (LAST=23, DAD 22:16, ADR 15:8, DATA 7:0).
  - The entry width constant 24.
  - The FAIL index constant 8'hFF.
- One sub-module, iic_seq_gap_timer: 16-bit load/decrement counter with a zero flag, used by GAP.

## Test plan
- 3-entry table {0x5D/0x07/0xA1, 0x5D/0x08/0x42, LAST 0x74/0x00/0x18}, channel model clean:
  - Three requests in order, each with NUM=0x00 and RNW=0.
  - DONE_OUT=1, FAIL_OUT=0, BUSY_OUT=0.
- ERR on entry 1, first two attempts only:
  - Entry 1 requested 3 times, GAP cycles between attempts.
  - DONE_OUT=1.
- ERR on entry 2, every attempt:
  - Exactly 4 requests for entry 2.
  - FAIL_OUT=1, ERR_IDX_OUT=2.
- INIT_ERR_IN pulsed during XFER:
  - FAIL follows the BSY fall.
  - ERR_IDX_OUT=8'hFF, no further REQ.
- RESET_IN asserted while REQ is high:
  - REQ=0 in the same cycle.
  - After release, START restarts from index 0.
- Verify enabled, model returns 0x00 for write 0xA1:
  - Read issued after each write.
  - Mismatch retried RETRY times, then FAIL with ERR_IDX_OUT=0.

Source files
------------

// File: rtl/iic_seq_pkg.sv
// Shared types and constants for the IIC boot-time configuration sequencer.
// Holds the sequencer state enum, command-table entry field positions and
// the index reported when the switch front end itself fails to initialise.
package iic_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_REQ,
    ST_XFER,
    ST_VREQ,
    ST_VXFER,
    ST_CHECK,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } seq_state_t;

  // Command table entry: {LAST, DAD[6:0], ADR[7:0], DATA[7:0]}
  localparam int ENTRY_W  = 24;
  localparam int LAST_BIT = 23;
  localparam int DAD_MSB  = 22;
  localparam int DAD_LSB  = 16;
  localparam int ADR_MSB  = 15;
  localparam int ADR_LSB  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  // Reported on ERR_IDX_OUT when the switch init failure forces FAIL
  localparam logic [7:0] FAIL_IDX = 8'hFF;

  // Channel byte count is encoded as count-1, so 8'h00 means one byte
  localparam logic [7:0] NUM_ONE_BYTE = 8'h00;

endpackage

// File: rtl/iic_seq_gap_timer.sv
// Retry gap timer: 16-bit load/decrement counter with a zero flag.
// Latency: load and decrement take effect on the next CLK_IN edge; saturates at 0.
// Ports: CLK_IN/RESET_IN (async, active-high), load + load_val, dec, zero.
module iic_seq_gap_timer (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] cnt;

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 16'd0)) begin
      cnt <= cnt - 16'd1;
    end
  end

  assign zero = (cnt == 16'd0);

endmodule

// File: rtl/iic_cfg_sequencer.sv
// Boot-time config sequencer: walks a table of 1-byte IIC register writes,
// retrying failed entries after a gap; START to first IIC_REQ_OUT is 3 cycles.
// Backpressure: IIC_REQ_OUT holds until IIC_RAK_IN, completion waits for IIC_BSY_IN low.
// Ports: CLK_IN, RESET_IN (async, active-high), START_IN, status BUSY/DONE/FAIL_OUT,
//   ERR_IDX_OUT, table port TBL_ADR_OUT/TBL_DAT_IN (1-cycle read), channel request
//   IIC_*_OUT, channel response IIC_*_IN, INIT_ERR_IN (switch init failure).
// Build option: define IIC_SEQ_VERIFY_EN to read back and compare each clean write.
module iic_cfg_sequencer #(
  parameter logic [7:0]  ENTRIES = 8'd32,
  parameter logic [1:0]  RETRY   = 2'd3,
  parameter logic [15:0] GAP     = 16'd2000
) (
  input  logic        CLK_IN,
  input  logic        RESET_IN,
  input  logic        START_IN,
  output logic        BUSY_OUT,
  output logic        DONE_OUT,
  output logic        FAIL_OUT,
  output logic [7:0]  ERR_IDX_OUT,
  output logic [7:0]  TBL_ADR_OUT,
  input  logic [23:0] TBL_DAT_IN,
  output logic        IIC_REQ_OUT,
  output logic [7:0]  IIC_NUM_OUT,
  output logic [6:0]  IIC_DAD_OUT,
  output logic [7:0]  IIC_ADR_OUT,
  output logic        IIC_RNW_OUT,
  output logic [7:0]  IIC_WDT_OUT,
  input  logic        IIC_RAK_IN,
  input  logic        IIC_WDA_IN,
  input  logic        IIC_WAE_IN,
  input  logic        IIC_BSY_IN,
  input  logic [7:0]  IIC_RDT_IN,
  input  logic        IIC_RVL_IN,
  input  logic        IIC_EOR_IN,
  input  logic        IIC_ERR_IN,
  input  logic        INIT_ERR_IN
);

  import iic_seq_pkg::*;

  seq_state_t  state;
  logic [7:0]  index;
  logic [1:0]  attempt;
  logic        err_f;
  logic        last_f;
  logic        init_pend;
  logic        xfer_end;
  logic        abort;
  logic        tmr_dec;
  logic        tmr_zero;
  logic        unused_in;

  // Write-acknowledge status is informational only; a missing WDA is not an error.
`ifdef IIC_SEQ_VERIFY_EN
  logic        rvl_seen;
  logic        rd_bad;

  // Readback fails on a data mismatch, a channel error, or BSY falling with no RVL.
  assign rd_bad = (IIC_RVL_IN && (IIC_RDT_IN != IIC_WDT_OUT)) ||
                  (IIC_ERR_IN && IIC_BSY_IN) ||
                  (!IIC_BSY_IN && !rvl_seen && !IIC_RVL_IN);
  assign unused_in = ^{IIC_WDA_IN, IIC_WAE_IN, IIC_EOR_IN};
`else
  assign unused_in = ^{IIC_WDA_IN, IIC_WAE_IN, IIC_EOR_IN, IIC_RVL_IN, IIC_RDT_IN};
`endif

  assign TBL_ADR_OUT = index;
  assign IIC_NUM_OUT = NUM_ONE_BYTE;

  // A transaction is complete on the first BSY-low cycle after RAK.
  assign xfer_end = ((state == ST_XFER) || (state == ST_VXFER)) && !IIC_BSY_IN;

  // Switch init failure: immediate when nothing is on the channel, otherwise
  // remembered in init_pend and taken once the outstanding transfer completes.
  assign abort = (INIT_ERR_IN && (state inside {ST_FETCH, ST_LOAD, ST_CHECK, ST_GAP, ST_DONE})) ||
                 (xfer_end && (init_pend || INIT_ERR_IN));

  // The timer is loaded at transfer end so CHECK counts as the first idle gap cycle.
  assign tmr_dec = (state == ST_CHECK) || (state == ST_GAP);

  iic_seq_gap_timer u_gap_timer (
    .CLK_IN   (CLK_IN),
    .RESET_IN (RESET_IN),
    .load     (xfer_end),
    .load_val (GAP - 16'd1),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state       <= ST_IDLE;
      index       <= '0;
      attempt     <= '0;
      err_f       <= 1'b0;
      last_f      <= 1'b0;
      init_pend   <= 1'b0;
      BUSY_OUT    <= 1'b0;
      DONE_OUT    <= 1'b0;
      FAIL_OUT    <= 1'b0;
      ERR_IDX_OUT <= '0;
      IIC_REQ_OUT <= 1'b0;
      IIC_DAD_OUT <= '0;
      IIC_ADR_OUT <= '0;
      IIC_RNW_OUT <= 1'b0;
      IIC_WDT_OUT <= '0;
`ifdef IIC_SEQ_VERIFY_EN
      rvl_seen    <= 1'b0;
`endif
    end else begin
      init_pend <= init_pend | INIT_ERR_IN;
      if (abort) begin
        state       <= ST_FAIL;
        BUSY_OUT    <= 1'b0;
        FAIL_OUT    <= 1'b1;
        ERR_IDX_OUT <= FAIL_IDX;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (START_IN) begin
              state       <= ST_FETCH;
              index       <= '0;
              attempt     <= '0;
              init_pend   <= 1'b0;
              BUSY_OUT    <= 1'b1;
              DONE_OUT    <= 1'b0;
              FAIL_OUT    <= 1'b0;
              ERR_IDX_OUT <= '0;
            end
          end
          ST_FETCH: state <= ST_LOAD;
          ST_LOAD: begin
            // Retries reuse the captured entry; only a fresh fetch reloads it.
            if (attempt == 2'd0) begin
              last_f      <= TBL_DAT_IN[LAST_BIT];
              IIC_DAD_OUT <= TBL_DAT_IN[DAD_MSB:DAD_LSB];
              IIC_ADR_OUT <= TBL_DAT_IN[ADR_MSB:ADR_LSB];
              IIC_WDT_OUT <= TBL_DAT_IN[DATA_MSB:DATA_LSB];
            end
            IIC_RNW_OUT <= 1'b0;
            IIC_REQ_OUT <= 1'b1;
            err_f       <= 1'b0;
            state       <= ST_REQ;
          end
          ST_REQ: begin
            if (IIC_RAK_IN) begin
              IIC_REQ_OUT <= 1'b0;
              err_f       <= err_f | IIC_ERR_IN;
              state       <= ST_XFER;
            end
          end
          ST_XFER: begin
            err_f <= err_f | (IIC_ERR_IN & IIC_BSY_IN);
            if (!IIC_BSY_IN) begin
`ifdef IIC_SEQ_VERIFY_EN
              if (!err_f) begin
                IIC_RNW_OUT <= 1'b1;
                IIC_REQ_OUT <= 1'b1;
                rvl_seen    <= 1'b0;
                state       <= ST_VREQ;
              end else begin
                state <= ST_CHECK;
              end
`else
              state <= ST_CHECK;
`endif
            end
          end
`ifdef IIC_SEQ_VERIFY_EN
          ST_VREQ: begin
            if (IIC_RAK_IN) begin
              IIC_REQ_OUT <= 1'b0;
              err_f       <= err_f | IIC_ERR_IN;
              state       <= ST_VXFER;
            end
          end
          ST_VXFER: begin
            err_f <= err_f | rd_bad;
            if (IIC_RVL_IN) rvl_seen <= 1'b1;
            if (!IIC_BSY_IN) state <= ST_CHECK;
          end
`endif
          ST_CHECK: begin
            if (!err_f) begin
              // The last table slot ends the walk even without LAST; no wrap.
              if (last_f || (index == (ENTRIES - 8'd1))) begin
                state    <= ST_DONE;
                DONE_OUT <= 1'b1;
                BUSY_OUT <= 1'b0;
              end else begin
                index   <= index + 8'd1;
                attempt <= '0;
                state   <= ST_FETCH;
              end
            end else if (attempt < RETRY) begin
              attempt <= attempt + 2'd1;
              state   <= ST_GAP;
            end else begin
              state       <= ST_FAIL;
              FAIL_OUT    <= 1'b1;
              BUSY_OUT    <= 1'b0;
              ERR_IDX_OUT <= index;
            end
          end
          ST_GAP: begin
            if (tmr_zero) state <= ST_LOAD;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
